// File: rtl/alu_issue.sv
// alu_issue: operand-issue and write-back stage around a combinational ALU.
//
// Accepts one reg-reg or reg-imm operation per cycle (valid/ready), reads
// operands from an internal 32x32 register file, and drives the ALU from a
// registered execute (E) stage. The ALU result is captured into a result (R)
// stage, written back to rd, and presented downstream with backpressure.
//
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   in_valid/in_ready           operation handshake
//   in_op, in_rs, in_rt, in_rd  opcode and register indices
//   in_use_imm, in_imm          immediate select and value for operand B
//   ALU_DA, ALU_DB, ALUOp       registered ALU operands and opcode
//   ALU_DC, ALU_zero            combinational ALU result and zero flag
//   out_valid/out_ready         result handshake
//   out_data, out_zero, out_rd  captured result, zero flag, destination
//   dbg_addr, dbg_data          combinational register-file read port
module alu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic        in_use_imm,
  input  logic [31:0] in_imm,
  output logic [31:0] ALU_DA,
  output logic [31:0] ALU_DB,
  output logic [2:0]  ALUOp,
  input  logic [31:0] ALU_DC,
  input  logic        ALU_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_zero,
  output logic [4:0]  out_rd,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic        e_valid;
  logic [31:0] e_a;
  logic [31:0] e_b;
  logic [2:0]  e_op;
  logic [4:0]  e_rd;

  logic [31:0] regs [32];

  logic        acc;
  logic        e_fire;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;

  assign e_fire   = e_valid & (~out_valid | out_ready);
  assign in_ready = ~e_valid | e_fire;
  assign acc      = in_valid & in_ready;

  assign ALU_DA = e_a;
  assign ALU_DB = e_b;
  assign ALUOp  = e_op;

  // The register being written this cycle is forwarded from ALU_DC, since
  // the array only updates at the edge that also captures the new operands.
  // The R stage is already committed to the array, so it needs no forwarding.
  always_comb begin
    opnd_a = '0;
    opnd_b = '0;
    if (in_rs != '0)
      opnd_a = (e_fire && e_rd == in_rs) ? ALU_DC : regs[in_rs];
    if (in_use_imm)
      opnd_b = in_imm;
    else if (in_rt != '0)
      opnd_b = (e_fire && e_rd == in_rt) ? ALU_DC : regs[in_rt];
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  // Execute stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid <= 1'b0;
      e_a     <= '0;
      e_b     <= '0;
      e_op    <= '0;
      e_rd    <= '0;
    end else if (acc) begin
      e_valid <= 1'b1;
      e_a     <= opnd_a;
      e_b     <= opnd_b;
      e_op    <= in_op;
      e_rd    <= in_rd;
    end else if (e_fire) begin
      e_valid <= 1'b0;
    end
  end

  // Result stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b0;
      out_rd    <= '0;
    end else if (e_fire) begin
      out_valid <= 1'b1;
      out_data  <= ALU_DC;
      out_zero  <= ALU_zero;
      out_rd    <= e_rd;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Register file; write-back happens when the result leaves E
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (e_fire && e_rd != '0) begin
      regs[e_rd] <= ALU_DC;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic        in_use_imm;
  logic [31:0] in_imm;
  logic [31:0] ALU_DA;
  logic [31:0] ALU_DB;
  logic [2:0]  ALUOp;
  logic [31:0] ALU_DC;
  logic        ALU_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_total = 0;
  int n_bad   = 0;

  alu_issue dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .ALU_DA(ALU_DA), .ALU_DB(ALU_DB), .ALUOp(ALUOp),
    .ALU_DC(ALU_DC), .ALU_zero(ALU_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_rd(out_rd),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ALU model: 000 = add, 001 = sub
  assign ALU_DC   = (ALUOp == 3'b001) ? (ALU_DA - ALU_DB) : (ALU_DA + ALU_DB);
  assign ALU_zero = (ALU_DC == 32'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic ui, input logic [31:0] imm);
    in_valid   = 1'b1;
    in_op      = op;
    in_rs      = rs;
    in_rt      = rt;
    in_rd      = rd;
    in_use_imm = ui;
    in_imm     = imm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic rd_reg(input logic [4:0] a, input string tag, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_use_imm = 1'b0; in_imm = '0; out_ready = 1'b1; dbg_addr = '0;
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_da", ALU_DA, 32'd0);
    chk("rst_db", ALU_DB, 32'd0);
    chk("rst_op", {29'd0, ALUOp}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) rd_reg(i[4:0], "rst_dbg", 32'd0);

    // Immediate load r1 = 5
    drive(3'b000, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5);
    tick(); idle();
    chk("imm_da", ALU_DA, 32'd0);
    chk("imm_db", ALU_DB, 32'd5);
    chk("imm_ov_early", {31'd0, out_valid}, 32'd0);
    tick();
    chk("imm_ov", {31'd0, out_valid}, 32'd1);
    chk("imm_data", out_data, 32'd5);
    chk("imm_zero", {31'd0, out_zero}, 32'd0);
    chk("imm_rd", {27'd0, out_rd}, 32'd1);
    rd_reg(5'd1, "imm_r1", 32'd5);

    // Preload r2 = 3, then r1 = 7 followed by r2 = r1 - r1 through the bypass
    drive(3'b000, 5'd0, 5'd0, 5'd2, 1'b1, 32'd3);
    tick(); idle(); tick(); tick();
    rd_reg(5'd2, "pre_r2", 32'd3);
    drive(3'b000, 5'd0, 5'd0, 5'd1, 1'b1, 32'd7);
    tick();
    drive(3'b001, 5'd1, 5'd1, 5'd2, 1'b0, 32'd0);
    tick(); idle();
    chk("byp_da", ALU_DA, 32'd7);
    chk("byp_db", ALU_DB, 32'd7);
    chk("byp_op", {29'd0, ALUOp}, 32'd1);
    chk("byp_first", out_data, 32'd7);
    tick();
    chk("byp_data", out_data, 32'd0);
    chk("byp_zero", {31'd0, out_zero}, 32'd1);
    chk("byp_rd", {27'd0, out_rd}, 32'd2);
    rd_reg(5'd2, "byp_r2", 32'd0);
    rd_reg(5'd1, "byp_r1", 32'd7);

    // Write to r0 followed directly by a read of r0: no write, no bypass
    tick();
    drive(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 32'd9);
    tick();
    drive(3'b000, 5'd0, 5'd0, 5'd3, 1'b1, 32'd1);
    tick(); idle();
    chk("r0_data", out_data, 32'd9);
    chk("r0_rd", {27'd0, out_rd}, 32'd0);
    chk("r0_ov", {31'd0, out_valid}, 32'd1);
    chk("r0_da", ALU_DA, 32'd0);
    rd_reg(5'd0, "r0_dbg", 32'd0);
    tick();
    chk("r3_data", out_data, 32'd1);
    rd_reg(5'd3, "r3_dbg", 32'd1);
    tick();
    chk("drain_ov", {31'd0, out_valid}, 32'd0);

    // Backpressure with three operations
    out_ready = 1'b0;
    drive(3'b000, 5'd0, 5'd0, 5'd4, 1'b1, 32'd11);
    tick();
    drive(3'b000, 5'd0, 5'd0, 5'd5, 1'b1, 32'd22);
    tick();
    drive(3'b000, 5'd0, 5'd0, 5'd6, 1'b1, 32'd33);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("bp_ov", {31'd0, out_valid}, 32'd1);
      chk("bp_data", out_data, 32'd11);
      chk("bp_rd", {27'd0, out_rd}, 32'd4);
      chk("bp_db", ALU_DB, 32'd22);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      rd_reg(5'd5, "bp_r5", 32'd0);
      rd_reg(5'd4, "bp_r4", 32'd11);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", {31'd0, in_ready}, 32'd1);
    tick(); idle();
    chk("bp2_ov", {31'd0, out_valid}, 32'd1);
    chk("bp2_data", out_data, 32'd22);
    chk("bp2_rd", {27'd0, out_rd}, 32'd5);
    chk("bp3_db", ALU_DB, 32'd33);
    rd_reg(5'd5, "bp_r5_wr", 32'd22);
    tick();
    chk("bp3_data", out_data, 32'd33);
    chk("bp3_rd", {27'd0, out_rd}, 32'd6);
    tick();
    chk("bp_end_ov", {31'd0, out_valid}, 32'd0);
    rd_reg(5'd6, "bp_r6", 32'd33);

    // Reset while E and R are both full
    out_ready = 1'b0;
    drive(3'b000, 5'd0, 5'd0, 5'd7, 1'b1, 32'd44);
    tick();
    drive(3'b000, 5'd0, 5'd0, 5'd8, 1'b1, 32'd55);
    tick(); idle();
    chk("mr_pre_ov", {31'd0, out_valid}, 32'd1);
    chk("mr_pre_db", ALU_DB, 32'd55);
    reset = 1'b1;
    #1;
    chk("mr_ov", {31'd0, out_valid}, 32'd0);
    chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mr_da", ALU_DA, 32'd0);
    chk("mr_db", ALU_DB, 32'd0);
    chk("mr_data", out_data, 32'd0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    chk("mr_ov_after", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 32; i++) rd_reg(i[4:0], "mr_dbg", 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
